// File: rtl/adder_4b.sv
// Registered unsigned adder: WIDTH-bit operands, WIDTH+1-bit sum with carry-out.
// Define ADDER_4B_INPUT_REG_EN to register the operands first (2-cycle latency).
module adder_4b #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    output logic [WIDTH:0]   data_out
);

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum_d;
    logic [WIDTH:0]   sum_q;

`ifdef ADDER_4B_INPUT_REG_EN
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // Operand stage clears with the output so the first sum after release is 0+0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= data_in1;
            b_q <= data_in2;
        end
    end

    assign op_a = a_q;
    assign op_b = b_q;
`else
    assign op_a = data_in1;
    assign op_b = data_in2;
`endif

    always_comb begin
        sum_d = {1'b0, op_a} + {1'b0, op_b};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign data_out = sum_q;

endmodule

// File: tb/tb_adder_4b.sv
// Self-checking bench for adder_4b at WIDTH=4 and WIDTH=8.
// Latency follows ADDER_4B_INPUT_REG_EN.
module tb_adder_4b;

    logic       clock;
    logic       reset;
    logic [3:0] a4, b4;
    logic [4:0] out4;
    logic [7:0] a8, b8;
    logic [8:0] out8;

    int n_chk  = 0;
    int n_fail = 0;
    int q4[$];
    int q8[$];
    int e4, e8;

`ifdef ADDER_4B_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    adder_4b #(.WIDTH(4)) u4 (
        .clock    (clock),
        .reset    (reset),
        .data_in1 (a4),
        .data_in2 (b4),
        .data_out (out4)
    );

    adder_4b #(.WIDTH(8)) u8 (
        .clock    (clock),
        .reset    (reset),
        .data_in1 (a8),
        .data_in2 (b8),
        .data_out (out8)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Model pipeline: after reset release it holds LAT-1 pending zero sums.
    task automatic model_reset();
        q4.delete();
        q8.delete();
        for (int i = 0; i < LAT - 1; i++) begin
            q4.push_back(0);
            q8.push_back(0);
        end
    endtask

    task automatic model_edge(input int a, input int b,
                              input int c, input int d);
        if (reset) begin
            q4.push_back(a + b);
            q8.push_back(c + d);
            e4 = q4.pop_front();
            e8 = q8.pop_front();
        end else begin
            e4 = 0;
            e8 = 0;
        end
    endtask

    // Called at a falling edge; drives inputs, checks after the rising edge.
    task automatic step(input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] c, input logic [7:0] d,
                        input string tag);
        a4 = a;
        b4 = b;
        a8 = c;
        b8 = d;
        @(posedge clock);
        model_edge(int'(a), int'(b), int'(c), int'(d));
        #1;
        chk({tag, "_w4"}, int'(out4), e4);
        chk({tag, "_w8"}, int'(out8), e8);
        @(negedge clock);
    endtask

    initial begin
        logic [3:0] seq_a[4];
        logic [3:0] seq_b[4];
        logic [3:0] bnd_a[4];
        logic [3:0] bnd_b[4];
        seq_a = '{4'h0, 4'hF, 4'h3, 4'h5};
        seq_b = '{4'hA, 4'hC, 4'hF, 4'h0};
        bnd_a = '{4'hF, 4'hF, 4'h0, 4'h8};
        bnd_b = '{4'hF, 4'h1, 4'h0, 4'h8};

        reset = 1'b0;
        a4 = 4'hF;
        b4 = 4'hF;
        a8 = 8'hFF;
        b8 = 8'hFF;
        e4 = 0;
        e8 = 0;

        // In reset with all-ones inputs: output stays 0 before and across an edge.
        #5;
        chk("rst_pre_edge", int'(out4), 0);
        @(posedge clock);
        #1;
        chk("rst_edge_w4", int'(out4), 0);
        chk("rst_edge_w8", int'(out8), 0);

        @(negedge clock);
        reset = 1'b1;
        model_reset();

        for (int i = 0; i < 4; i++)
            step(seq_a[i], seq_b[i], 8'(i * 37), 8'(i * 91), "seq");

        step(bnd_a[0], bnd_b[0], 8'hFF, 8'hFF, "max_max");
        step(bnd_a[1], bnd_b[1], 8'hFF, 8'h01, "max_one");
        step(bnd_a[2], bnd_b[2], 8'h00, 8'h00, "zero");
        step(bnd_a[3], bnd_b[3], 8'h80, 8'h80, "half");
        // Flush so every directed sum reaches the output.
        for (int i = 0; i < LAT; i++)
            step(4'h3, 4'h4, 8'h30, 8'h40, "hold_fill");

        // Constant inputs: output must stay 0x07 at both edges of each cycle.
        for (int i = 0; i < 5; i++) begin
            step(4'h3, 4'h4, 8'h30, 8'h40, "hold");
            chk("hold_mid", int'(out4), 7);
        end

        // Mid-stream reset: (7,9) applied after an edge, reset half a cycle later.
        @(posedge clock);
        model_edge(3, 4, 8'h30, 8'h40);
        #2;
        chk("pre_rst", int'(out4), e4);
        a4 = 4'h7;
        b4 = 4'h9;
        a8 = 8'h77;
        b8 = 8'h99;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_async_w4", int'(out4), 0);
        chk("rst_async_w8", int'(out8), 0);
        @(posedge clock);
        #1;
        chk("rst_held", int'(out4), 0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < LAT + 1; i++)
            step(4'h2, 4'h3, 8'h12, 8'h34, "post_rst");

        for (int i = 0; i < 1000; i++)
            step(4'($urandom), 4'($urandom),
                 8'($urandom), 8'($urandom), "rand");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
